// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative restoring divider and its requester.
package div_iter_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_ZERO = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   // Width of the iteration counter; never narrower than one bit.
   function automatic int counter_width(input int iter);
      if (iter < 2) begin
         return 1;
      end
      return $clog2(iter);
   endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the
// divisor and keep the difference only when it does not go negative.
module div_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             quot_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem_in < divisor always holds, so the trial difference fits WIDTH+1 bits
   // and its top bit is a clean borrow flag.
   always_comb begin
      shifted  = {rem_in, dividend_bit};
      trial    = shifted - {1'b0, divisor};
      quot_bit = ~trial[WIDTH];
      rem_out  = quot_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider with configurable width and radix, explicit
// divide-by-zero handling, abort support and a start/ready handshake.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic                 annul_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   output logic                 busy_o,
   output logic                 ready_o,
   output logic                 div_by_zero_o,
   output logic [2*WIDTH-1:0]   result_o
);

   localparam int ITER  = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = counter_width(ITER);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITER - 1);

   div_state_e state;
   div_state_e next_state;

   // dividend_sh holds the remaining dividend bits at the top and collects
   // quotient bits at the bottom as the operation proceeds.
   logic [WIDTH-1:0]   dividend_sh;
   logic [WIDTH-1:0]   divisor_mag;
   logic [WIDTH-1:0]   rem;
   logic [CNT_W-1:0]   count;
   logic               neg_quot;
   logic               neg_rem;
   logic [2*WIDTH-1:0] result;
   logic               dbz;

   logic               accept;
   logic               divisor_zero;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [BITS_PER_CYCLE:0][WIDTH-1:0] rem_chain;
   logic [BITS_PER_CYCLE-1:0]          quot_bits;
   logic [WIDTH-1:0]                   step_quot;
   logic [WIDTH-1:0]                   final_quot;
   logic [WIDTH-1:0]                   final_rem;
   logic                               last_step;

   // Operand conditioning at request time: the most negative value keeps its
   // own bit pattern as magnitude, which is exactly right on an unsigned datapath.
   always_comb begin
      accept       = (start_i == DivStart) && !annul_i;
      divisor_zero = (opdata2_i == '0);
      a_neg        = signed_i & opdata1_i[WIDTH-1];
      b_neg        = signed_i & opdata2_i[WIDTH-1];
      a_mag        = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
      b_mag        = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
   end

   assign rem_chain[0] = rem;

   // Chain of restoring steps retiring BITS_PER_CYCLE quotient bits per clock,
   // most significant dividend bit first.
   for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
      div_iter_step #(
         .WIDTH(WIDTH)
      ) u_step (
         .rem_in       (rem_chain[k]),
         .dividend_bit (dividend_sh[WIDTH-1-k]),
         .divisor      (divisor_mag),
         .rem_out      (rem_chain[k+1]),
         .quot_bit     (quot_bits[BITS_PER_CYCLE-1-k])
      );
   end

   if (BITS_PER_CYCLE == WIDTH) begin : g_shift_all
      assign step_quot = quot_bits;
   end else begin : g_shift_part
      assign step_quot = {dividend_sh[WIDTH-1-BITS_PER_CYCLE:0], quot_bits};
   end

   // Sign correction applied on the final step: quotient negative when the
   // operand signs differ, remainder follows the dividend.
   always_comb begin
      last_step  = (count == LAST_COUNT);
      final_quot = neg_quot ? (~step_quot + 1'b1) : step_quot;
      final_rem  = neg_rem ? (~rem_chain[BITS_PER_CYCLE] + 1'b1) : rem_chain[BITS_PER_CYCLE];
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= DIV_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; annul overrides every other transition.
   always_comb begin
      next_state = state;
      unique case (state)
         DIV_IDLE: begin
            if (accept) begin
               next_state = divisor_zero ? DIV_ZERO : DIV_BUSY;
            end
         end
         DIV_ZERO: begin
            next_state = annul_i ? DIV_IDLE : DIV_DONE;
         end
         DIV_BUSY: begin
            if (annul_i) begin
               next_state = DIV_IDLE;
            end else if (last_step) begin
               next_state = DIV_DONE;
            end
         end
         DIV_DONE: begin
            if (annul_i || (start_i == DivStop)) begin
               next_state = DIV_IDLE;
            end
         end
         default: next_state = DIV_IDLE;
      endcase
   end

   // Datapath registers: latch operands on accept, iterate in BUSY, and only
   // write the result register when an operation completes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dividend_sh <= '0;
         divisor_mag <= '0;
         rem         <= '0;
         count       <= '0;
         neg_quot    <= 1'b0;
         neg_rem     <= 1'b0;
         result      <= '0;
         dbz         <= 1'b0;
      end else begin
         unique case (state)
            DIV_IDLE: begin
               if (accept) begin
                  rem   <= '0;
                  count <= '0;
                  if (divisor_zero) begin
                     dividend_sh <= opdata1_i;
                  end else begin
                     dividend_sh <= a_mag;
                     divisor_mag <= b_mag;
                     neg_quot    <= a_neg ^ b_neg;
                     neg_rem     <= a_neg;
                  end
               end
            end
            DIV_ZERO: begin
               if (!annul_i) begin
                  result <= {dividend_sh, {WIDTH{1'b1}}};
                  dbz    <= 1'b1;
               end
            end
            DIV_BUSY: begin
               if (!annul_i) begin
                  dividend_sh <= step_quot;
                  rem         <= rem_chain[BITS_PER_CYCLE];
                  count       <= count + CNT_W'(1);
                  if (last_step) begin
                     result <= {final_rem, final_quot};
                     dbz    <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy_o        = (state == DIV_BUSY) || (state == DIV_ZERO);
   assign ready_o       = (state == DIV_DONE) ? DivResultReady : DivResultNotReady;
   assign div_by_zero_o = dbz;
   assign result_o      = result;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench: three divider instances (1, 2 and 4 bits per cycle)
// compared against an arithmetic reference model.
module tb_div_iter;

   localparam int W = 32;
   localparam int N = 3;

   logic           clk = 1'b0;
   logic           resetn;
   logic [N-1:0]   start;
   logic           sgn;
   logic           annul;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic [N-1:0]   busy;
   logic [N-1:0]   ready;
   logic [N-1:0]   dbz;
   logic [2*W-1:0] result [N];

   int checks = 0;
   int errors = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      div_iter #(
         .WIDTH          (W),
         .BITS_PER_CYCLE (1 << g)
      ) u_dut (
         .clk           (clk),
         .resetn        (resetn),
         .start_i       (start[g]),
         .signed_i      (sgn),
         .annul_i       (annul),
         .opdata1_i     (op_a),
         .opdata2_i     (op_b),
         .busy_o        (busy[g]),
         .ready_o       (ready[g]),
         .div_by_zero_o (dbz[g]),
         .result_o      (result[g])
      );
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
      end
   endtask

   // Reference: plain integer division, truncating toward zero in signed mode.
   function automatic logic [63:0] refDivide(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint x;
      longint y;
      longint q;
      longint r;
      if (b == 32'd0) begin
         return {a, 32'hFFFF_FFFF};
      end
      if (s) begin
         x = longint'(signed'(a));
         y = longint'(signed'(b));
      end else begin
         x = longint'({32'd0, a});
         y = longint'({32'd0, b});
      end
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic applyStimulus(input int idx, input logic s, input logic [31:0] a,
                                input logic [31:0] b, input int hold);
      logic [63:0] expected;
      int          edges;
      int          latency;
      logic        busy_ok;
      string       pfx;
      pfx      = $sformatf("u%0d_%0s_%h_%h", idx, s ? "s" : "u", a, b);
      expected = refDivide(s, a, b);
      latency  = (b == 32'd0) ? 1 : (32 >> idx);
      @(negedge clk);
      sgn        = s;
      op_a       = a;
      op_b       = b;
      start[idx] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op_a  = $urandom;
      op_b  = $urandom;
      sgn   = 1'($urandom_range(0, 1));
      edges   = 0;
      busy_ok = 1'b1;
      while (ready[idx] !== 1'b1 && edges < 100) begin
         busy_ok &= (busy[idx] === 1'b1);
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      checkOutput({pfx, "_latency"}, 64'(edges), 64'(latency));
      checkOutput({pfx, "_busy_run"}, 64'(busy_ok), 64'd1);
      checkOutput({pfx, "_result"}, result[idx], expected);
      checkOutput({pfx, "_dbz"}, 64'(dbz[idx]), 64'(b == 32'd0));
      checkOutput({pfx, "_busy_done"}, 64'(busy[idx]), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput({pfx, "_hold_ready"}, 64'(ready[idx]), 64'd1);
         checkOutput({pfx, "_hold_result"}, result[idx], expected);
      end
      start[idx] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({pfx, "_drop_ready"}, 64'(ready[idx]), 64'd0);
      checkOutput({pfx, "_drop_busy"}, 64'(busy[idx]), 64'd0);
   endtask

   task automatic checkIdleZero(input string tag, input int idx);
      checkOutput({tag, "_result"}, result[idx], 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy[idx]), 64'd0);
      checkOutput({tag, "_ready"}, 64'(ready[idx]), 64'd0);
      checkOutput({tag, "_dbz"}, 64'(dbz[idx]), 64'd0);
   endtask

   initial begin
      logic        ready_seen;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      int          mode;

      resetn = 1'b0;
      start  = '0;
      annul  = 1'b0;
      sgn    = 1'b0;
      op_a   = '0;
      op_b   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         checkIdleZero($sformatf("reset_u%0d", i), i);
      end
      resetn = 1'b1;

      // Directed cases on the 1-bit-per-cycle instance.
      applyStimulus(0, 1'b0, 32'd100, 32'd7, 5);
      applyStimulus(0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      applyStimulus(0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
      applyStimulus(0, 1'b0, 32'd5, 32'd0, 0);
      applyStimulus(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      applyStimulus(1, 1'b0, 32'd100, 32'd7, 2);
      applyStimulus(2, 1'b0, 32'd100, 32'd7, 2);

      // Abort in BUSY cycle 10: no result may appear afterwards.
      @(negedge clk);
      sgn      = 1'b0;
      op_a     = 32'd1234567;
      op_b     = 32'd89;
      start[0] = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul    = 1'b1;
      start[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      annul = 1'b0;
      checkOutput("annul_busy", 64'(busy[0]), 64'd0);
      checkOutput("annul_ready", 64'(ready[0]), 64'd0);
      ready_seen = 1'b0;
      repeat (35) begin
         @(posedge clk);
         @(negedge clk);
         ready_seen |= (ready[0] === 1'b1);
      end
      checkOutput("annul_no_ready", 64'(ready_seen), 64'd0);
      applyStimulus(0, 1'b0, 32'd9, 32'd3, 0);

      // Asynchronous reset mid-BUSY clears everything without a clock edge.
      @(negedge clk);
      sgn      = 1'b0;
      op_a     = 32'd1000;
      op_b     = 32'd3;
      start[0] = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      checkIdleZero("async_reset", 0);
      @(negedge clk);
      start[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus(0, 1'b0, 32'd9, 32'd3, 0);

      // Randomized operands on all three radix settings.
      for (int idx = 0; idx < N; idx++) begin
         for (int n = 0; n < 10; n++) begin
            mode = $urandom_range(0, 5);
            s    = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            case (mode)
               0: b = 32'd0;
               1: begin
                  s = 1'b1;
                  a = 32'h8000_0000;
                  b = 32'hFFFF_FFFF;
               end
               2: b = 32'($urandom_range(1, 15));
               3: b = {1'b1, b[30:0]};
               default: begin
               end
            endcase
            applyStimulus(idx, s, a, b, n % 2);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
